// File: rtl/al_demux_pkg.sv
// al_demux_pkg
// Shared constants and types for the 1-to-4 valid/ready demultiplexer.
//   NPORT   : number of output ports
//   SELW    : width of the destination select
//   state_e : packet-tracking FSM states (IDLE, BURST)
package al_demux_pkg;

  localparam int NPORT = 4;
  localparam int SELW  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/al_demux_slot.sv
// al_demux_slot
// Single-entry registered holding stage with valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   load       : write load_data/load_last into the slot this edge
//   load_data  : payload to capture
//   load_last  : last flag to capture
//   can_load   : slot is empty or draining this cycle, so it may be loaded
//   o_valid    : slot holds a beat
//   o_ready    : downstream accepts the held beat
//   o_data     : held payload, stable while o_valid && !o_ready
//   o_last     : held last flag
module al_demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  output logic         can_load,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_last
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  // A draining slot can take a new beat on the same edge, which is what
  // gives back-to-back throughput without a skid buffer.
  assign can_load = !valid_q || o_ready;

  // Drain clears the slot; a load on the same edge wins and keeps it valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (valid_q && o_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: rtl/al_map_demux4.sv
// al_map_demux4
// Routes a valid/ready input stream to one of four registered output ports.
// With PKT=1 the destination is locked for the whole packet (until i_last);
// with PKT=0 the destination is sampled on every beat.
//   clk, rst  : clock, synchronous active-high reset
//   i_valid   : input beat valid
//   i_ready   : input beat accepted when i_valid && i_ready
//   i_data    : input payload (W bits)
//   i_last    : final beat of a packet
//   s         : destination port select
//   o_valid   : per-port valid, bit n = port n
//   o_ready   : per-port downstream ready
//   o_data    : port n payload on bits [n*W +: W]
//   o_last    : per-port last flag
module al_map_demux4
  import al_demux_pkg::*;
#(
  parameter int W   = 8,
  parameter int PKT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [W-1:0]       i_data,
  input  logic               i_last,
  input  logic [SELW-1:0]    s,
  output logic [NPORT-1:0]   o_valid,
  input  logic [NPORT-1:0]   o_ready,
  output logic [NPORT*W-1:0] o_data,
  output logic [NPORT-1:0]   o_last
);

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   eff_sel;
  logic [NPORT-1:0]  sel_oh;
  logic [NPORT-1:0]  slot_can_load;
  logic [NPORT-1:0]  slot_load;
  logic              accept;

  // Inside a packet the locked select wins; otherwise s is used directly.
  assign eff_sel = (PKT != 0 && state_q == BURST) ? sel_q : s;

  // Equality compare rather than a shift: an unknown select matches no
  // port, so no slot loads and i_ready drops in simulation.
  always_comb begin
    sel_oh = '0;
    for (int n = 0; n < NPORT; n++) begin
      if (eff_sel == SELW'(n)) begin
        sel_oh[n] = 1'b1;
      end
    end
  end

  // Only the selected port's occupancy gates the input.
  assign i_ready   = !rst && |(sel_oh & slot_can_load);
  assign accept    = i_valid && i_ready;
  assign slot_load = accept ? sel_oh : '0;

  // Packet tracking: a non-last accept opens a burst and locks s; a last
  // accept closes it. Single-beat packets never leave IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (PKT != 0 && accept) begin
      if (state_q == IDLE && !i_last) begin
        state_d = BURST;
        sel_d   = s;
      end else if (state_q == BURST && i_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  for (genvar n = 0; n < NPORT; n++) begin : g_slot
    al_demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[n]),
      .load_data (i_data),
      .load_last (i_last),
      .can_load  (slot_can_load[n]),
      .o_valid   (o_valid[n]),
      .o_ready   (o_ready[n]),
      .o_data    (o_data[n*W +: W]),
      .o_last    (o_last[n])
    );
  end

endmodule

// File: tb/tb_al_map_demux4.sv
// tb_al_map_demux4
// Drives a per-beat (PKT=0) and a per-packet (PKT=1) instance from the same
// stimulus and compares both against a behavioural model every cycle, plus
// directed vector rows with hand-computed expectations for the PKT=1 copy.
module tb_al_map_demux4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_last;
  logic [1:0]  s;
  logic [3:0]  o_ready;

  logic        i_ready0, i_ready1;
  logic [3:0]  o_valid0, o_valid1;
  logic [31:0] o_data0, o_data1;
  logic [3:0]  o_last0, o_last1;

  int checks   = 0;
  int failures = 0;

  logic pre_ready0, pre_ready1;

  // Behavioural reference: one entry per instance (0 = PKT0, 1 = PKT1)
  logic [3:0] mv   [2];
  logic [7:0] md   [2][4];
  logic [3:0] ml   [2];
  logic       mpkt [2];
  logic       mbusy[2];
  logic [1:0] msel [2];
  logic       xrdy [2];
  logic [1:0] xeff [2];

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [1:0] sv;
    logic [3:0] ordy;
    logic       x_rdy;
    logic [3:0] x_vld;
    int         port;
    logic [7:0] x_d;
    logic       x_l;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  al_map_demux4 #(.W(8), .PKT(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready0),
    .i_data(i_data), .i_last(i_last), .s(s),
    .o_valid(o_valid0), .o_ready(o_ready), .o_data(o_data0), .o_last(o_last0)
  );

  al_map_demux4 #(.W(8), .PKT(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready1),
    .i_data(i_data), .i_last(i_last), .s(s),
    .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1), .o_last(o_last1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, check ready
  // before the rising edge, advance the model, check outputs after it.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [7:0] d, input logic l,
                               input logic [1:0] sv, input logic [3:0] ordy);
    @(negedge clk);
    rst = r; i_valid = v; i_data = d; i_last = l; s = sv; o_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      xeff[k] = (mpkt[k] && mbusy[k]) ? msel[k] : sv;
      xrdy[k] = !r && (!mv[k][xeff[k]] || ordy[xeff[k]]);
    end
    pre_ready0 = i_ready0;
    pre_ready1 = i_ready1;
    checkOutput("m0_i_ready", {31'd0, i_ready0}, {31'd0, xrdy[0]});
    checkOutput("m1_i_ready", {31'd0, i_ready1}, {31'd0, xrdy[1]});
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mv[k] = '0; ml[k] = '0; mbusy[k] = 1'b0; msel[k] = '0;
        for (int p = 0; p < 4; p++) md[k][p] = '0;
      end else begin
        mv[k] = mv[k] & ~ordy;
        if (v && xrdy[k]) begin
          mv[k][xeff[k]] = 1'b1;
          md[k][xeff[k]] = d;
          ml[k][xeff[k]] = l;
          if (mpkt[k]) begin
            if (!mbusy[k] && !l) begin
              mbusy[k] = 1'b1;
              msel[k]  = sv;
            end else if (mbusy[k] && l) begin
              mbusy[k] = 1'b0;
            end
          end
        end
      end
    end
    #1;
    checkOutput("m0_o_valid", {28'd0, o_valid0}, {28'd0, mv[0]});
    checkOutput("m1_o_valid", {28'd0, o_valid1}, {28'd0, mv[1]});
    checkOutput("m0_o_data", o_data0, {md[0][3], md[0][2], md[0][1], md[0][0]});
    checkOutput("m1_o_data", o_data1, {md[1][3], md[1][2], md[1][1], md[1][0]});
    checkOutput("m0_o_last", {28'd0, o_last0}, {28'd0, ml[0]});
    checkOutput("m1_o_last", {28'd0, o_last1}, {28'd0, ml[1]});
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; s = '0; o_ready = '0;
    for (int k = 0; k < 2; k++) begin
      mv[k] = '0; ml[k] = '0; mbusy[k] = 1'b0; msel[k] = '0;
      xrdy[k] = 1'b0; xeff[k] = '0;
      for (int p = 0; p < 4; p++) md[k][p] = '0;
    end
    mpkt[0] = 1'b0;
    mpkt[1] = 1'b1;

    // Reset state
    applyStimulus(1, 0, 8'h00, 0, 2'd0, 4'hF);
    checkOutput("rst_ready", {31'd0, pre_ready1}, 32'd0);
    applyStimulus(1, 1, 8'h5A, 0, 2'd1, 4'hF);
    checkOutput("rst_ready_valid", {31'd0, pre_ready1}, 32'd0);
    checkOutput("rst_o_valid", {28'd0, o_valid0 | o_valid1}, 32'd0);
    checkOutput("rst_o_data", o_data0 | o_data1, 32'd0);

    // Per-beat instance: single beat to port 2
    applyStimulus(0, 1, 8'hA5, 1, 2'd2, 4'hF);
    checkOutput("t1_ready", {31'd0, pre_ready0}, 32'd1);
    checkOutput("t1_o_valid", {28'd0, o_valid0}, 32'b0100);
    checkOutput("t1_o_data", {24'd0, o_data0[23:16]}, 32'hA5);
    applyStimulus(0, 0, 8'h00, 0, 2'd2, 4'hF);
    checkOutput("t1_ready_held", {31'd0, pre_ready0}, 32'd1);

    // Locked packet to port 1 with s toggled mid-packet, then s followed again
    vq.push_back('{0, 1, 8'h11, 0, 2'd1, 4'hF, 1, 4'b0010, 1, 8'h11, 0});
    vq.push_back('{0, 1, 8'h22, 0, 2'd3, 4'hF, 1, 4'b0010, 1, 8'h22, 0});
    vq.push_back('{0, 1, 8'h33, 1, 2'd3, 4'hF, 1, 4'b0010, 1, 8'h33, 1});
    vq.push_back('{0, 1, 8'h44, 1, 2'd3, 4'hF, 1, 4'b1000, 3, 8'h44, 1});
    // Backpressure on port 0: second beat waits, then drain and load together
    vq.push_back('{0, 1, 8'hA1, 1, 2'd0, 4'hE, 1, 4'b0001, 0, 8'hA1, 1});
    vq.push_back('{0, 1, 8'hA2, 1, 2'd0, 4'hE, 0, 4'b0001, 0, 8'hA1, 1});
    vq.push_back('{0, 1, 8'hA2, 1, 2'd0, 4'hF, 1, 4'b0001, 0, 8'hA2, 1});
    vq.push_back('{0, 0, 8'h00, 0, 2'd0, 4'hF, 1, 4'b0000, 0, 8'hA2, 1});
    // Port 2 stalled while port 3 loads and streams
    vq.push_back('{0, 1, 8'hB2, 1, 2'd2, 4'hB, 1, 4'b0100, 2, 8'hB2, 1});
    vq.push_back('{0, 1, 8'hB3, 1, 2'd3, 4'hB, 1, 4'b1100, 3, 8'hB3, 1});
    for (int i = 0; i < 16; i++) begin
      vq.push_back('{0, 1, 8'hC0 + 8'(i), 1, 2'd3, 4'hB, 1, 4'b1100, 3,
                     8'hC0 + 8'(i), 1});
    end
    vq.push_back('{0, 0, 8'h00, 0, 2'd2, 4'hB, 0, 4'b0100, 2, 8'hB2, 1});
    vq.push_back('{0, 0, 8'h00, 0, 2'd0, 4'hF, 1, 4'b0000, 2, 8'hB2, 1});
    // Reset in the middle of a packet, then a fresh packet to port 0
    vq.push_back('{0, 1, 8'h51, 0, 2'd1, 4'hF, 1, 4'b0010, 1, 8'h51, 0});
    vq.push_back('{1, 1, 8'h52, 0, 2'd1, 4'hF, 0, 4'b0000, 1, 8'h00, 0});
    vq.push_back('{0, 1, 8'h61, 0, 2'd0, 4'hF, 1, 4'b0001, 0, 8'h61, 0});
    vq.push_back('{0, 1, 8'h62, 1, 2'd2, 4'hF, 1, 4'b0001, 0, 8'h62, 1});
    // Single-beat packet stays in IDLE; the next beat follows s
    vq.push_back('{0, 1, 8'h71, 1, 2'd3, 4'hF, 1, 4'b1000, 3, 8'h71, 1});
    vq.push_back('{0, 1, 8'h72, 1, 2'd2, 4'hF, 1, 4'b0100, 2, 8'h72, 1});
    vq.push_back('{0, 0, 8'h00, 0, 2'd0, 4'hF, 1, 4'b0000, 2, 8'h72, 1});

    foreach (vq[i]) begin
      applyStimulus(vq[i].r, vq[i].v, vq[i].d, vq[i].l, vq[i].sv, vq[i].ordy);
      checkOutput($sformatf("vec%0d_ready", i), {31'd0, pre_ready1},
                  {31'd0, vq[i].x_rdy});
      checkOutput($sformatf("vec%0d_o_valid", i), {28'd0, o_valid1},
                  {28'd0, vq[i].x_vld});
      checkOutput($sformatf("vec%0d_o_data", i),
                  {24'd0, o_data1[vq[i].port*8 +: 8]}, {24'd0, vq[i].x_d});
      checkOutput($sformatf("vec%0d_o_last", i),
                  {31'd0, o_last1[vq[i].port]}, {31'd0, vq[i].x_l});
    end

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                    8'($urandom), $urandom_range(0, 3) == 0,
                    2'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
